// File: rtl/ccd_line_timing_gen.sv
// ccd_line_timing_gen: linear-CCD line timing generator (pre-gap, SH pulse, post-gap, pixel shift, line gap).
// Define CCD_CLAMP_EN to add the cp_puls clamp output; the default build has no clamp port.
module ccd_line_timing_gen #(
  parameter int PIXELS   = 2088,
  parameter int SH_PRE   = 5,
  parameter int SH_WIDTH = 25,
  parameter int SH_POST  = 5,
  parameter int CNT_W    = 25,
  parameter int IDX_W    = 12,
  parameter int CP_WIDTH = 2
) (
  input  logic             pxl_clk,
  input  logic             rst,
  input  logic             trigger_mode,
  input  logic             ext_trigger,
  input  logic [CNT_W-1:0] f_cnt,
  output logic             sh_puls,
  output logic             f2_puls,
  output logic             rs_puls,
  output logic             os_tvalid,
  output logic [IDX_W-1:0] pxl_idx,
  output logic             line_start,
  output logic             trig_overrun
`ifdef CCD_CLAMP_EN
  , output logic           cp_puls
`endif
);

  localparam int LOAD_LEN = SH_PRE + SH_WIDTH + SH_POST;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_LOAD = 3'b001;
  localparam logic [2:0] ST_TRAN = 3'b010;
  localparam logic [2:0] ST_WAIT = 3'b100;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0] TRAN_LAST = CNT_W'(PIXELS - 1);
  localparam logic [CNT_W-1:0] SH_ON     = CNT_W'(SH_PRE);
  localparam logic [CNT_W-1:0] SH_OFF    = CNT_W'(SH_PRE + SH_WIDTH);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] gap_shadow;
  logic             mode_q;
  logic             trig_s1, trig_s2, trig_s3, trig_edge;
  logic             busy;

  // Two-flop synchroniser, edge register, then a registered edge pulse so
  // line_start lands three edges after ext_trigger is first sampled high.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_s3   <= 1'b0;
      trig_edge <= 1'b0;
    end else begin
      trig_s1   <= ext_trigger;
      trig_s2   <= trig_s1;
      trig_s3   <= trig_s2;
      trig_edge <= trig_s2 & ~trig_s3;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (!trigger_mode || trig_edge) state_nxt = ST_LOAD;
      end
      ST_LOAD: if (cnt == LOAD_LAST) begin
        state_nxt = ST_TRAN;
        cnt_nxt   = '0;
      end
      ST_TRAN: if (cnt == TRAN_LAST) begin
        state_nxt = ST_WAIT;
        cnt_nxt   = '0;
      end
      ST_WAIT: if (mode_q || cnt == gap_shadow) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == ST_LOAD) || (state == ST_TRAN) || (state == ST_WAIT);

  // Mode is latched only while idle and the gap on the first LOAD cycle, so
  // register writes mid-line take effect on the following line.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      mode_q     <= 1'b0;
      gap_shadow <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == ST_IDLE) mode_q <= trigger_mode;
      if (state == ST_LOAD && cnt == '0) gap_shadow <= f_cnt;
    end
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      sh_puls      <= 1'b0;
      f2_puls      <= 1'b1;
      rs_puls      <= 1'b1;
      os_tvalid    <= 1'b0;
      pxl_idx      <= '0;
      line_start   <= 1'b0;
      trig_overrun <= 1'b0;
    end else begin
      sh_puls      <= (state_nxt == ST_LOAD) && (cnt_nxt >= SH_ON) && (cnt_nxt < SH_OFF);
      f2_puls      <= (state_nxt != ST_LOAD);
      rs_puls      <= (state_nxt != ST_LOAD);
      os_tvalid    <= (state_nxt == ST_TRAN);
      pxl_idx      <= (state_nxt == ST_TRAN) ? cnt_nxt[IDX_W-1:0] : '0;
      line_start   <= (state == ST_IDLE) && (state_nxt == ST_LOAD);
      trig_overrun <= trig_edge && busy;
    end
  end

`ifdef CCD_CLAMP_EN
  localparam logic [CNT_W-1:0] CP_END = CNT_W'(CP_WIDTH);

  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) cp_puls <= 1'b0;
    else     cp_puls <= (state_nxt == ST_TRAN) && (cnt_nxt < CP_END);
  end
`endif

endmodule

// File: tb/tb_ccd_line_timing_gen.sv
// tb_ccd_line_timing_gen: directed bench for ccd_line_timing_gen with a small sensor geometry
// (PIXELS=16, SH_PRE=2, SH_WIDTH=4, SH_POST=2, CNT_W=8); honours CCD_CLAMP_EN if defined.
module tb_ccd_line_timing_gen;

  logic       pxl_clk = 1'b0;
  logic       rst;
  logic       trigger_mode;
  logic       ext_trigger;
  logic [7:0] f_cnt;
  logic       sh_puls, f2_puls, rs_puls, os_tvalid, line_start, trig_overrun;
  logic [3:0] pxl_idx;
`ifdef CCD_CLAMP_EN
  logic       cp_puls;
`endif

  int checks = 0;
  int passes = 0;

  int period, sh_first, sh_last, sh_cnt, f2_low, tv_first, tv_cnt, idx_err, ovr_at, ovr_cnt, cp_err;
  int n;

  ccd_line_timing_gen #(
    .PIXELS(16), .SH_PRE(2), .SH_WIDTH(4), .SH_POST(2),
    .CNT_W(8), .IDX_W(4), .CP_WIDTH(2)
  ) dut (
    .pxl_clk(pxl_clk),
    .rst(rst),
    .trigger_mode(trigger_mode),
    .ext_trigger(ext_trigger),
    .f_cnt(f_cnt),
    .sh_puls(sh_puls),
    .f2_puls(f2_puls),
    .rs_puls(rs_puls),
    .os_tvalid(os_tvalid),
    .pxl_idx(pxl_idx),
    .line_start(line_start),
    .trig_overrun(trig_overrun)
`ifdef CCD_CLAMP_EN
    , .cp_puls(cp_puls)
`endif
  );

  always #5 pxl_clk = ~pxl_clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic mode, input logic ext, input logic [7:0] gap);
    trigger_mode = mode;
    ext_trigger  = ext;
    f_cnt        = gap;
  endtask

  task automatic waitLineStart(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge pxl_clk);
      if (line_start) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Called at the negedge where line_start is seen; walks the line cycle by cycle.
  task automatic measureLine(input int rise_at, input int fall_at, input int chg_at,
                             input logic [7:0] chg_val, input int budget);
    period = -1; sh_first = -1; sh_last = -1; sh_cnt = 0; f2_low = 0;
    tv_first = -1; tv_cnt = 0; idx_err = 0; ovr_at = -1; ovr_cnt = 0; cp_err = 0;
    for (int k = 0; k < budget; k++) begin
      if (k > 0 && line_start) begin
        period = k;
        break;
      end
      if (sh_puls) begin
        if (sh_cnt == 0) sh_first = k;
        sh_last = k;
        sh_cnt++;
      end
      if (!f2_puls) f2_low++;
      if (rs_puls !== f2_puls) idx_err++;
      if (os_tvalid) begin
        if (tv_cnt == 0) tv_first = k;
        if (int'(pxl_idx) != k - tv_first) idx_err++;
        tv_cnt++;
      end else if (pxl_idx != 4'd0) idx_err++;
      if (trig_overrun) begin
        ovr_at = k;
        ovr_cnt++;
      end
`ifdef CCD_CLAMP_EN
      if (cp_puls !== (os_tvalid && pxl_idx < 4'd2)) cp_err++;
`endif
      if (k == rise_at) ext_trigger = 1'b1;
      if (k == fall_at) ext_trigger = 1'b0;
      if (k == chg_at)  f_cnt = chg_val;
      @(negedge pxl_clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd3);
    repeat (2) @(negedge pxl_clk);
    checkOutput("rst_sh", int'(sh_puls), 0);
    checkOutput("rst_f2", int'(f2_puls), 1);
    checkOutput("rst_rs", int'(rs_puls), 1);
    checkOutput("rst_tvalid", int'(os_tvalid), 0);
    checkOutput("rst_idx", int'(pxl_idx), 0);
    checkOutput("rst_line_start", int'(line_start), 0);
    checkOutput("rst_overrun", int'(trig_overrun), 0);
    rst = 1'b0;

    // Free-run with f_cnt=3: 1 + 8 + 16 + 4 = 29 cycles per line.
    waitLineStart(5, n);
    checkOutput("first_line_latency", n, 1);
    measureLine(-1, -1, -1, 8'd0, 100);
    checkOutput("m0_period", period, 29);
    checkOutput("m0_sh_first", sh_first, 2);
    checkOutput("m0_sh_last", sh_last, 5);
    checkOutput("m0_sh_cnt", sh_cnt, 4);
    checkOutput("m0_f2_low", f2_low, 8);
    checkOutput("m0_tv_first", tv_first, 8);
    checkOutput("m0_tv_cnt", tv_cnt, 16);
    checkOutput("m0_idx_err", idx_err, 0);
    checkOutput("m0_overrun", ovr_cnt, 0);
`ifdef CCD_CLAMP_EN
    checkOutput("m0_cp_err", cp_err, 0);
`endif

    // Gap change mid-TRAN only affects the following line.
    measureLine(-1, -1, 12, 8'd10, 100);
    checkOutput("gapchg_cur_period", period, 29);
    measureLine(-1, -1, -1, 8'd0, 100);
    checkOutput("gapchg_next_period", period, 36);
    measureLine(-1, -1, 0, 8'd3, 100);
    checkOutput("gap_restore_period", period, 29);

    // All-ones gap: WAIT runs 256 cycles without wrapping.
    measureLine(-1, -1, 0, 8'd255, 400);
    checkOutput("gapmax_period", period, 281);
    checkOutput("gapmax_idx_err", idx_err, 0);
    measureLine(-1, -1, 0, 8'd3, 400);
    checkOutput("gapmax_restore_period", period, 29);

    // Switch to external mode mid-line: current line finishes, then IDLE holds.
    trigger_mode = 1'b1;
    measureLine(-1, -1, -1, 8'd0, 60);
    checkOutput("m1_idle_hold", period, -1);

    // External edge -> line_start on the fourth negedge; re-trigger lands in
    // the IDLE cycle right after the single WAIT cycle and is accepted.
    ext_trigger = 1'b1;
    waitLineStart(10, n);
    checkOutput("m1_trig_latency", n, 4);
    measureLine(22, 3, -1, 8'd0, 60);
    checkOutput("m1_b2b_period", period, 26);
    checkOutput("m1_b2b_overrun", ovr_cnt, 0);
    checkOutput("m1_tv_cnt", tv_cnt, 16);

    // Edge during TRAN is dropped with a one-cycle overrun pulse.
    measureLine(10, 2, -1, 8'd0, 60);
    checkOutput("ovr_no_extra_line", period, -1);
    checkOutput("ovr_cnt", ovr_cnt, 1);
    checkOutput("ovr_at", ovr_at, 14);
    checkOutput("ovr_tv_cnt", tv_cnt, 16);

    // Asynchronous reset mid-TRAN, then restart from IDLE in free-run mode.
    applyStimulus(1'b0, 1'b0, 8'd3);
    waitLineStart(5, n);
    checkOutput("m0_resume_latency", n, 1);
    repeat (12) @(negedge pxl_clk);
    checkOutput("pre_rst_tvalid", int'(os_tvalid), 1);
    checkOutput("pre_rst_idx", int'(pxl_idx), 4);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_tvalid", int'(os_tvalid), 0);
    checkOutput("async_rst_f2", int'(f2_puls), 1);
    checkOutput("async_rst_rs", int'(rs_puls), 1);
    checkOutput("async_rst_sh", int'(sh_puls), 0);
    checkOutput("async_rst_idx", int'(pxl_idx), 0);
    @(negedge pxl_clk);
    rst = 1'b0;
    waitLineStart(5, n);
    checkOutput("post_rst_latency", n, 1);
    measureLine(-1, -1, -1, 8'd0, 100);
    checkOutput("post_rst_period", period, 29);
    checkOutput("post_rst_overrun", ovr_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
